// File: rtl/spi_mnrch_param.sv
// SPI master: one WIDTH-bit frame per wrt pulse, all four CPOL/CPHA modes,
// SCLK = clk / 2^DIV_LOG2, one of NUM_SS active-low selects.
module spi_mnrch_param #(
    parameter int WIDTH    = 16,
    parameter int DIV_LOG2 = 4,
    parameter int NUM_SS   = 1,
    localparam int SELW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [WIDTH-1:0]  wt_data,
    input  logic [1:0]        mode,
    input  logic [SELW-1:0]   ss_sel,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n,
    output logic              SCLK,
    output logic              MOSI,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  rd_data
);
    localparam int CW = DIV_LOG2 - 1;
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, FRNT, XFER, BACK} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     hcnt;
    logic [BW-1:0]     bcnt;
    logic              ph;
    logic              pend;
    logic              miso_q;
    logic [1:0]        mode_q;
    logic [WIDTH-1:0]  sreg;
    logic [NUM_SS-1:0] ss_dec;
    logic              accept, tick, sclk_tgl, sample_now, shift_now, last_edge;

    // hcnt spans exactly one half-period, so all-ones marks the next event
    assign tick       = &hcnt;
    assign accept     = (state == IDLE) && wrt;
    assign sclk_tgl   = tick && ((state == FRNT) || (state == XFER));
    // ph=0 means the upcoming SCLK edge is odd; CPHA=0 samples odd edges
    assign sample_now = sclk_tgl && (ph == mode_q[0]);
    assign shift_now  = tick && pend;
    assign last_edge  = ph && (bcnt == BW'(WIDTH - 1));

    always_comb begin
        for (int i = 0; i < NUM_SS; i++)
            ss_dec[i] = (ss_sel != SELW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (wrt)               state_nxt = FRNT;
            FRNT: if (tick)              state_nxt = XFER;
            XFER: if (tick && last_edge) state_nxt = BACK;
            BACK: if (tick)              state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            bcnt   <= '0;
            ph     <= 1'b0;
            pend   <= 1'b0;
            miso_q <= 1'b0;
            mode_q <= 2'b11;
            sreg   <= '0;
            SS_n   <= '1;
            SCLK   <= 1'b1;
            done   <= 1'b0;
        end else if (accept) begin
            hcnt   <= '0;
            bcnt   <= '0;
            ph     <= 1'b0;
            pend   <= 1'b0;
            mode_q <= mode;
            sreg   <= wt_data;
            SS_n   <= ss_dec;
            SCLK   <= mode[1];
            done   <= 1'b0;
        end else if (state != IDLE) begin
            hcnt <= hcnt + 1'b1;
            if (sclk_tgl) begin
                SCLK <= ~SCLK;
                ph   <= ~ph;
                if (ph) bcnt <= bcnt + 1'b1;
            end
            if (shift_now) begin
                sreg <= {sreg[WIDTH-2:0], miso_q};
                pend <= 1'b0;
            end
            if (sample_now) begin
                miso_q <= MISO;
                pend   <= 1'b1;
            end
            if ((state == BACK) && tick) begin
                SS_n <= '1;
                done <= 1'b1;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign MOSI    = sreg[WIDTH-1];
    assign rd_data = sreg;
endmodule
